// File: rtl/fwd_scoreboard_if.sv
// Signal bundle for fwd_scoreboard: EX operands, MEM/WB forwarding sources and load scoreboard traffic.
// With FWD_STATS_EN defined the bundle also carries the stall/forward statistics counters.
interface fwd_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int RA_W = 5
);
  logic                   i_ex_valid;
  logic [NSRC*RA_W-1:0]   i_ex_rs;
  logic [NSRC*XLEN-1:0]   i_ex_rs_data;
  logic [NSRC*XLEN-1:0]   o_rs_data;
  logic                   o_stall;
  logic [RA_W-1:0]        i_mem_rd;
  logic                   i_mem_sig_regwrite;
  logic [1:0]             i_mem_sig_regwrsrc;
  logic [XLEN-1:0]        i_mem_aluresult;
  logic [XLEN-1:0]        i_mem_imm;
  logic [XLEN-1:0]        i_mem_pc;
  logic [RA_W-1:0]        i_wb_rd;
  logic                   i_wb_sig_regwrite;
  logic [XLEN-1:0]        i_wb_rd_data;
  logic                   i_ld_issue;
  logic [RA_W-1:0]        i_ld_issue_rd;
  logic                   i_ld_resp_valid;
  logic [XLEN-1:0]        i_ld_resp_data;
  logic                   o_ld_full;
  logic                   o_err;
`ifdef FWD_STATS_EN
  logic [31:0]            o_stat_stall_cycles;
  logic [31:0]            o_stat_fwd_count;
`endif

  modport master (
    output i_ex_valid, i_ex_rs, i_ex_rs_data,
    output i_mem_rd, i_mem_sig_regwrite, i_mem_sig_regwrsrc, i_mem_aluresult, i_mem_imm, i_mem_pc,
    output i_wb_rd, i_wb_sig_regwrite, i_wb_rd_data,
    output i_ld_issue, i_ld_issue_rd, i_ld_resp_valid, i_ld_resp_data,
`ifdef FWD_STATS_EN
    input  o_stat_stall_cycles, o_stat_fwd_count,
`endif
    input  o_rs_data, o_stall, o_ld_full, o_err
  );

  modport slave (
    input  i_ex_valid, i_ex_rs, i_ex_rs_data,
    input  i_mem_rd, i_mem_sig_regwrite, i_mem_sig_regwrsrc, i_mem_aluresult, i_mem_imm, i_mem_pc,
    input  i_wb_rd, i_wb_sig_regwrite, i_wb_rd_data,
    input  i_ld_issue, i_ld_issue_rd, i_ld_resp_valid, i_ld_resp_data,
`ifdef FWD_STATS_EN
    output o_stat_stall_cycles, o_stat_fwd_count,
`endif
    output o_rs_data, o_stall, o_ld_full, o_err
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// EX-stage operand forwarding from MEM, outstanding loads and WB, with an in-order load scoreboard.
// Optional macro FWD_STATS_EN adds stall-cycle and forwarded-cycle counters.
module fwd_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NSRC    = 2,
  parameter int RA_W    = 5,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  fwd_scoreboard_if.slave bus
);
  localparam logic [1:0] REGWRSRC_ALU = 2'd0;
  localparam logic [1:0] REGWRSRC_MEM = 2'd1;
  localparam logic [1:0] REGWRSRC_IMM = 2'd2;
  localparam logic [1:0] REGWRSRC_PC4 = 2'd3;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [RA_W-1:0]      r_rd [MAX_OUT];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic                 r_err;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_stall;
  logic [NSRC-1:0]      w_stallReq;
  logic [NSRC-1:0]      w_fwd;
  logic [NSRC*XLEN-1:0] w_rsData;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Scanning oldest to youngest lets the last match win, which is the youngest writer of the register.
  always_comb begin
    logic [RA_W-1:0] w_src;
    logic            w_hit;
    logic            w_hitHead;
    logic [PW-1:0]   w_idx;
    w_stallReq = '0;
    w_fwd      = '0;
    w_rsData   = bus.i_ex_rs_data;
    for (int i = 0; i < NSRC; i++) begin
      w_src     = bus.i_ex_rs[i*RA_W +: RA_W];
      w_hit     = 1'b0;
      w_hitHead = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < MAX_OUT; k++) begin
        w_idx = PW'((int'(r_head) + k) % MAX_OUT);
        if (k < int'(r_count) && r_rd[w_idx] == w_src) begin
          w_hit     = 1'b1;
          w_hitHead = (k == 0);
        end
      end
      if (w_src != '0) begin
        if (bus.i_mem_sig_regwrite && bus.i_mem_rd == w_src) begin
          case (bus.i_mem_sig_regwrsrc)
            REGWRSRC_ALU: begin
              w_rsData[i*XLEN +: XLEN] = bus.i_mem_aluresult;
              w_fwd[i]                 = 1'b1;
            end
            REGWRSRC_IMM: begin
              w_rsData[i*XLEN +: XLEN] = bus.i_mem_imm;
              w_fwd[i]                 = 1'b1;
            end
            REGWRSRC_PC4: begin
              w_rsData[i*XLEN +: XLEN] = bus.i_mem_pc + XLEN'(4);
              w_fwd[i]                 = 1'b1;
            end
            REGWRSRC_MEM: w_stallReq[i] = 1'b1;
            default:      w_stallReq[i] = 1'b1;
          endcase
        end else if (w_hit) begin
          if (w_hitHead && bus.i_ld_resp_valid) begin
            w_rsData[i*XLEN +: XLEN] = bus.i_ld_resp_data;
            w_fwd[i]                 = 1'b1;
          end else begin
            w_stallReq[i] = 1'b1;
          end
        end else if (bus.i_wb_sig_regwrite && bus.i_wb_rd == w_src) begin
          w_rsData[i*XLEN +: XLEN] = bus.i_wb_rd_data;
          w_fwd[i]                 = 1'b1;
        end
      end
    end
  end

  assign w_full  = (r_count == CW'(MAX_OUT));
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.i_ld_resp_valid && !w_empty;
  assign w_push  = bus.i_ld_issue && (!w_full || bus.i_ld_resp_valid);
  assign w_stall = bus.i_ex_valid && (|w_stallReq);

  assign bus.o_rs_data = w_rsData;
  assign bus.o_stall   = w_stall;
  assign bus.o_ld_full = w_full;
  assign bus.o_err     = r_err;

  // When full, head and tail coincide; a simultaneous pop frees the slot the push overwrites.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int k = 0; k < MAX_OUT; k++) begin
        r_rd[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_rd[r_tail] <= bus.i_ld_issue_rd;
        r_tail       <= ptrNext(r_tail);
      end
      if (w_pop) begin
        r_head <= ptrNext(r_head);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if ((bus.i_ld_issue && !w_push) || (bus.i_ld_resp_valid && w_empty)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] r_statStall;
  logic [31:0] r_statFwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statStall <= '0;
      r_statFwd   <= '0;
    end else begin
      if (w_stall) begin
        r_statStall <= r_statStall + 32'd1;
      end
      if (bus.i_ex_valid && (|w_fwd)) begin
        r_statFwd <= r_statFwd + 32'd1;
      end
    end
  end

  assign bus.o_stat_stall_cycles = r_statStall;
  assign bus.o_stat_fwd_count    = r_statFwd;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: directed cases then randomized traffic against a queue-based model.
// Statistics outputs are checked only when FWD_STATS_EN is defined.
module tb_fwd_scoreboard;
  localparam int XLEN    = 32;
  localparam int NSRC    = 2;
  localparam int RA_W    = 5;
  localparam int MAX_OUT = 4;
  localparam logic [1:0] WS_ALU = 2'd0;
  localparam logic [1:0] WS_MEM = 2'd1;
  localparam logic [1:0] WS_IMM = 2'd2;
  localparam logic [1:0] WS_PC4 = 2'd3;

  typedef struct {
    logic                 exValid;
    logic [NSRC*RA_W-1:0] rs;
    logic [NSRC*XLEN-1:0] rsData;
    logic [RA_W-1:0]      memRd;
    logic                 memRegwrite;
    logic [1:0]           memWrsrc;
    logic [XLEN-1:0]      memAlu;
    logic [XLEN-1:0]      memImm;
    logic [XLEN-1:0]      memPc;
    logic [RA_W-1:0]      wbRd;
    logic                 wbRegwrite;
    logic [XLEN-1:0]      wbData;
    logic                 ldIssue;
    logic [RA_W-1:0]      ldIssueRd;
    logic                 ldResp;
    logic [XLEN-1:0]      ldRespData;
  } stim_t;

  typedef struct {
    logic [NSRC*XLEN-1:0] rsData;
    logic                 stall;
    logic                 ldFull;
    logic                 err;
    logic                 anyFwd;
    logic [31:0]          statStall;
    logic [31:0]          statFwd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.XLEN(XLEN), .NSRC(NSRC), .RA_W(RA_W)) bus ();

  fwd_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .RA_W(RA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t            expQ[$];
  logic [RA_W-1:0] ldQ[$];
  logic            modelErr = 1'b0;
  logic [31:0]     modelStall = '0;
  logic [31:0]     modelFwd = '0;
  int              total = 0;
  int              bad = 0;

  function automatic stim_t idleStim();
    stim_t s;
    s.exValid     = 1'b0;
    s.rs          = '0;
    s.rsData      = {32'hA5A5_0002, 32'hA5A5_0001};
    s.memRd       = '0;
    s.memRegwrite = 1'b0;
    s.memWrsrc    = WS_ALU;
    s.memAlu      = '0;
    s.memImm      = '0;
    s.memPc       = '0;
    s.wbRd        = '0;
    s.wbRegwrite  = 1'b0;
    s.wbData      = '0;
    s.ldIssue     = 1'b0;
    s.ldIssueRd   = '0;
    s.ldResp      = 1'b0;
    s.ldRespData  = '0;
    return s;
  endfunction

  function automatic stim_t randomStim();
    stim_t s;
    s.exValid     = ($urandom_range(0, 9) < 8);
    s.rs          = {RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7))};
    s.rsData      = {$urandom(), $urandom()};
    s.memRd       = RA_W'($urandom_range(0, 7));
    s.memRegwrite = ($urandom_range(0, 1) == 1);
    s.memWrsrc    = 2'($urandom_range(0, 3));
    s.memAlu      = $urandom();
    s.memImm      = $urandom();
    s.memPc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
    s.wbRd        = RA_W'($urandom_range(0, 7));
    s.wbRegwrite  = ($urandom_range(0, 1) == 1);
    s.wbData      = $urandom();
    s.ldIssue     = ($urandom_range(0, 9) < 3);
    s.ldIssueRd   = RA_W'($urandom_range(0, 7));
    s.ldResp      = (ldQ.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
    s.ldRespData  = $urandom();
    return s;
  endfunction

  // Reference: each source looks in MEM, then the youngest queued load, then WB.
  function automatic exp_t computeExpected(input stim_t s);
    exp_t            e;
    logic            anyStall;
    logic            anyFwd;
    logic [RA_W-1:0] r;
    logic [XLEN-1:0] d;
    int              young;
    anyStall = 1'b0;
    anyFwd   = 1'b0;
    e.rsData = s.rsData;
    for (int i = 0; i < NSRC; i++) begin
      r     = s.rs[i*RA_W +: RA_W];
      d     = s.rsData[i*XLEN +: XLEN];
      young = -1;
      foreach (ldQ[j]) if (ldQ[j] == r) young = j;
      if (r != '0) begin
        if (s.memRegwrite && s.memRd == r) begin
          if (s.memWrsrc == WS_MEM) anyStall = 1'b1;
          else begin
            anyFwd = 1'b1;
            if (s.memWrsrc == WS_ALU) d = s.memAlu;
            else if (s.memWrsrc == WS_IMM) d = s.memImm;
            else d = s.memPc + 32'd4;
          end
        end else if (young >= 0) begin
          if (young == 0 && s.ldResp) begin
            d      = s.ldRespData;
            anyFwd = 1'b1;
          end else anyStall = 1'b1;
        end else if (s.wbRegwrite && s.wbRd == r) begin
          d      = s.wbData;
          anyFwd = 1'b1;
        end
      end
      e.rsData[i*XLEN +: XLEN] = d;
    end
    e.stall     = s.exValid && anyStall;
    e.anyFwd    = s.exValid && anyFwd;
    e.ldFull    = (ldQ.size() == MAX_OUT);
    e.err       = modelErr;
    e.statStall = modelStall;
    e.statFwd   = modelFwd;
    return e;
  endfunction

  task automatic updateModel(input stim_t s, input exp_t e);
    logic wasFull;
    wasFull = (ldQ.size() == MAX_OUT);
    if (s.ldResp) begin
      if (ldQ.size() > 0) void'(ldQ.pop_front());
      else modelErr = 1'b1;
    end
    if (s.ldIssue) begin
      if (wasFull && !s.ldResp) modelErr = 1'b1;
      else ldQ.push_back(s.ldIssueRd);
    end
    if (e.stall) modelStall = modelStall + 32'd1;
    if (e.anyFwd) modelFwd = modelFwd + 32'd1;
  endtask

  task automatic driveInputs(input stim_t s);
    bus.i_ex_valid         = s.exValid;
    bus.i_ex_rs            = s.rs;
    bus.i_ex_rs_data       = s.rsData;
    bus.i_mem_rd           = s.memRd;
    bus.i_mem_sig_regwrite = s.memRegwrite;
    bus.i_mem_sig_regwrsrc = s.memWrsrc;
    bus.i_mem_aluresult    = s.memAlu;
    bus.i_mem_imm          = s.memImm;
    bus.i_mem_pc           = s.memPc;
    bus.i_wb_rd            = s.wbRd;
    bus.i_wb_sig_regwrite  = s.wbRegwrite;
    bus.i_wb_rd_data       = s.wbData;
    bus.i_ld_issue         = s.ldIssue;
    bus.i_ld_issue_rd      = s.ldIssueRd;
    bus.i_ld_resp_valid    = s.ldResp;
    bus.i_ld_resp_data     = s.ldRespData;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    driveInputs(s);
    e = computeExpected(s);
    expQ.push_back(e);
    updateModel(s, e);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    driveInputs(idleStim());
    rst = 1'b1;
    ldQ.delete();
    modelErr   = 1'b0;
    modelStall = '0;
    modelFwd   = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (bus.o_rs_data !== e.rsData) begin
      bad++;
      $display("[TB] FAIL rs_data got=%h want=%h t=%0t", bus.o_rs_data, e.rsData, $time);
    end
    total++;
    if (bus.o_stall !== e.stall) begin
      bad++;
      $display("[TB] FAIL stall got=%b want=%b t=%0t", bus.o_stall, e.stall, $time);
    end
    total++;
    if (bus.o_ld_full !== e.ldFull) begin
      bad++;
      $display("[TB] FAIL ld_full got=%b want=%b t=%0t", bus.o_ld_full, e.ldFull, $time);
    end
    total++;
    if (bus.o_err !== e.err) begin
      bad++;
      $display("[TB] FAIL err got=%b want=%b t=%0t", bus.o_err, e.err, $time);
    end
`ifdef FWD_STATS_EN
    total++;
    if (bus.o_stat_stall_cycles !== e.statStall) begin
      bad++;
      $display("[TB] FAIL stat_stall_cycles got=%0d want=%0d t=%0t", bus.o_stat_stall_cycles, e.statStall, $time);
    end
    total++;
    if (bus.o_stat_fwd_count !== e.statFwd) begin
      bad++;
      $display("[TB] FAIL stat_fwd_count got=%0d want=%0d t=%0t", bus.o_stat_fwd_count, e.statFwd, $time);
    end
`endif
  endtask

  // Monitor: every expectation queued during a cycle is compared on that cycle's falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    stim_t s;
    driveInputs(idleStim());
    rst = 1'b1;
    #12;
    rst = 1'b0;

    s = idleStim();
    s.rs = {5'd6, 5'd5};
    applyStimulus(s);
    s.exValid = 1'b1;
    s.memRegwrite = 1'b1; s.memRd = 5'd5; s.memWrsrc = WS_ALU; s.memAlu = 32'h1234;
    s.wbRegwrite = 1'b1; s.wbRd = 5'd6; s.wbData = 32'hBEEF;
    applyStimulus(s);

    s = idleStim();
    s.exValid = 1'b1; s.rs = {5'd0, 5'd0};
    s.memRegwrite = 1'b1; s.memRd = 5'd0; s.memWrsrc = WS_PC4; s.memPc = 32'h100;
    applyStimulus(s);
    s.rs = {5'd0, 5'd7}; s.memRd = 5'd7; s.memPc = 32'hFFFF_FFFC;
    applyStimulus(s);

    s = idleStim();
    s.exValid = 1'b1; s.rs = {5'd0, 5'd9};
    s.memRegwrite = 1'b1; s.memRd = 5'd9; s.memWrsrc = WS_MEM;
    s.ldIssue = 1'b1; s.ldIssueRd = 5'd9;
    applyStimulus(s);
    s.memRegwrite = 1'b0; s.ldIssue = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    s.ldResp = 1'b1; s.ldRespData = 32'hCAFE_0001;
    applyStimulus(s);
    s.ldResp = 1'b0;
    applyStimulus(s);

    s = idleStim();
    s.ldIssue = 1'b1; s.ldIssueRd = 5'd3;
    applyStimulus(s);
    applyStimulus(s);
    s.ldIssue = 1'b0; s.exValid = 1'b1; s.rs = {5'd0, 5'd3};
    s.ldResp = 1'b1; s.ldRespData = 32'h0000_1111;
    applyStimulus(s);
    s.ldRespData = 32'h0000_2222;
    applyStimulus(s);
    s.ldResp = 1'b0;
    applyStimulus(s);

    s = idleStim();
    for (int k = 0; k < MAX_OUT; k++) begin
      s.ldIssue = 1'b1; s.ldIssueRd = RA_W'(10 + k);
      applyStimulus(s);
    end
    s.ldIssue = 1'b0;
    applyStimulus(s);
    s.ldIssue = 1'b1; s.ldIssueRd = 5'd20; s.ldResp = 1'b1; s.ldRespData = 32'h55;
    applyStimulus(s);
    s.ldResp = 1'b0; s.ldIssueRd = 5'd21;
    applyStimulus(s);
    s.ldIssue = 1'b0;
    applyStimulus(s);
    doReset();
    s = idleStim();
    applyStimulus(s);
    s.ldResp = 1'b1;
    applyStimulus(s);
    s.ldResp = 1'b0;
    applyStimulus(s);

    doReset();
    s = idleStim();
    s.exValid = 1'b1; s.rs = {5'd0, 5'd4};
    s.memRegwrite = 1'b1; s.memRd = 5'd4; s.memWrsrc = WS_MEM;
    repeat (3) applyStimulus(s);
    s.memWrsrc = WS_IMM; s.memImm = 32'h77;
    repeat (2) applyStimulus(s);
    applyStimulus(idleStim());

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus(randomStim());
    end

    @(negedge clk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Next-generation EX-stage operand forwarding unit with NSRC source operands and a load scoreboard for variable-latency data memory.
- Forwards from the MEM stage, in-flight loads and WB into EX.
- Tracks outstanding loads in an in-order FIFO and stalls EX on a true dependency until the load response arrives.
- Sits between the ID/EX register file read and the ALU operand muxes; `stall` feeds the hazard/pipeline-control logic.

Parameters:
- XLEN, 32, datapath width.
- NSRC, 2, number of EX source operands; source i uses slice i of each flattened bus.
- RA_W, 5, register address width.
- MAX_OUT, 4, maximum outstanding loads (FIFO depth, ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX holds a real instruction.
- ex_rs  in  NSRC*RA_W  EX source register indices.
- ex_rs_data  in  NSRC*XLEN  register-file read data.
- rs_data  out  NSRC*XLEN  forwarded operands.
- stall  out  1  hold IF/ID/EX and bubble MEM.
- mem_rd  in  RA_W  MEM destination register.
- mem_sig_regwrite  in  1  MEM writes rd.
- mem_sig_regwrsrc  in  2  MEM writeback source (REGWRSRC_ALU/MEM/IMM/PC4 codes).
- mem_aluresult, mem_imm, mem_pc  in  XLEN each  MEM candidate values.
- wb_rd  in  RA_W  WB destination.
- wb_sig_regwrite  in  1  WB writes rd.
- wb_rd_data  in  XLEN  WB data.
- ld_issue  in  1  load accepted by data memory this cycle.
- ld_issue_rd  in  RA_W  destination of the issued load.
- ld_resp_valid  in  1  oldest outstanding load returns data this cycle.
- ld_resp_data  in  XLEN  returned load data.
- ld_full  out  1  FIFO holds MAX_OUT entries.
- err  out  1  sticky: issue while full, or response while empty.

Behaviour:
- Reset: FIFO empty (count=0, pointers 0), `err`=0, `ld_full`=0. `rs_data`/`stall` are combinational; with no hazards, `rs_data`=`ex_rs_data` and `stall`=0.
- FIFO is circular with wrap-around pointers; each entry holds `rd`.
  - `ld_issue` pushes at the clock edge; `ld_resp_valid` pops the head at the edge.
  - Simultaneous push and pop: count unchanged, both pointers advance; allowed when full.
  - Push while full without pop: dropped, `err`←1.
  - Pop while empty: ignored, `err`←1.
  - Issued rd=0 is still pushed (keeps ordering) but never matches.
- Per-source priority (combinational), for source i with index r:
  1. r==0: `rs_data`=`ex_rs_data`, no stall.
  2. MEM hit (`mem_sig_regwrite`, `mem_rd`==r): ALU→`mem_aluresult`; IMM→`mem_imm`; PC4→`mem_pc`+4 (mod 2^XLEN); MEM→stall.
  3. FIFO hit: the youngest valid entry with rd==r decides.
     - If it is the head and `ld_resp_valid`=1: forward `ld_resp_data`, no stall.
     - Otherwise: stall.
  4. WB hit (`wb_sig_regwrite`, `wb_rd`==r): `wb_rd_data`.
  5. Otherwise: `ex_rs_data`.
- `stall` = `ex_valid` AND (any source requests a stall). When `ex_valid`=0, `stall`=0 but `rs_data` is still computed.
- Latency:
  - Issue at edge N is visible to matching from cycle N+1. In cycle N the load is still in MEM with wrsrc=MEM and stalls via rule 2.
  - Response forwarding has zero latency; the entry is gone from cycle N+1.
- `ld_full` = (count==MAX_OUT), combinational from registered count.
- Reset asserted mid-operation: FIFO flushed immediately; stalls release once the MEM/WB inputs clear. `err` is cleared only by reset.

Optional Feature:
- Macro `FWD_STATS_EN`.
- When defined, adds outputs:
  - `stat_stall_cycles` (32 bits): counts cycles with `stall`=1.
  - `stat_fwd_count` (32 bits): counts cycles with `ex_valid`=1 and at least one source forwarded by rules 2–4.
  - Both reset to 0 and wrap at 2^32.
- When not defined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- MEM ALU forward: ex_rs=(x5,x6); MEM rd=x5, ALU, result 0x1234; WB rd=x6, data 0xBEEF -> rs_data=(0x1234,0xBEEF), stall=0.
- PC4 and x0: MEM rd=x0 PC4 with ex_rs0=x0 -> passthrough; rd=x7 PC4 with pc=0xFFFFFFFC -> operand 0x00000000 (wrap).
- Scoreboard stall and release: issue load rd=x9; next cycles ex_rs0=x9, ex_valid=1 -> stall=1 until resp with data 0xCAFE0001, when rs_data0=0xCAFE0001 and stall=0 in the same cycle; count returns to 0.
- Youngest-match ordering: issue rd=x3, then rd=x3 again; first resp -> stall still 1 (younger entry matches); second resp -> forwards its data.
- Full/empty and simultaneous events: 4 issues -> ld_full=1; push+pop same cycle -> count stays 4, err=0; extra push -> err=1; reset -> count=0, err=0; pop while empty -> err=1.
- `FWD_STATS_EN` build: 3 stall cycles plus 2 forwarded cycles -> stat_stall_cycles=3, stat_fwd_count=2.
